hqc_frame_loader: RTL

Host-load front end for the HQC top-level wrappers, generalising the fixed CT/SK loader. It accepts a byte stream from the UART RX path as self-describing frames (sync, region id, length, payload, XOR checksum). Bytes are packed into words of configurable width and endianness and written into one of NUM_REGIONS target memories. It tracks which regions are loaded and signals the wrapper when every required region is present, replacing the single uart_done.

---
 rtl/hqc_frame_loader_pkg.sv | 22 ++
 rtl/hqc_frame_loader_if.sv | 28 ++
 rtl/hqc_word_packer.sv | 47 ++++
 rtl/hqc_frame_loader.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/hqc_frame_loader_pkg.sv
// Shared types and constants for the HQC host frame loader.
package hqc_loader_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_LEN0,
        ST_LEN1,
        ST_DATA,
        ST_CSUM
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_HDR     = 2'd1,
        ERR_CSUM    = 2'd2,
        ERR_TIMEOUT = 2'd3
    } err_code_t;

endpackage

// File: rtl/hqc_frame_loader_if.sv
// Byte-stream input and region write bus of the frame loader.
// The master side is the loader itself: it accepts bytes and drives writes.
interface hqc_frame_loader_if #(
    parameter int WORD_BYTES  = 8,
    parameter int NUM_REGIONS = 4,
    parameter int ADDR_W      = 12
);
    localparam int REG_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;

    logic                    in_valid;
    logic [7:0]              in_data;
    logic                    in_ready;
    logic                    wr_en;
    logic [REG_W-1:0]        wr_region;
    logic [ADDR_W-1:0]       wr_addr;
    logic [8*WORD_BYTES-1:0] wr_data;

    modport master (
        input  in_valid, in_data,
        output in_ready, wr_en, wr_region, wr_addr, wr_data
    );

    modport slave (
        output in_valid, in_data,
        input  in_ready, wr_en, wr_region, wr_addr, wr_data
    );

endinterface

// File: rtl/hqc_word_packer.sv
// Packs payload bytes into memory words; flags a word when its last lane
// fills or the frame's final byte arrives, with unfilled lanes left zero.
module hqc_word_packer #(
    parameter int WORD_BYTES = 8,
    parameter int BIG_ENDIAN = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    push,
    input  logic                    last,
    input  logic [7:0]              byte_in,
    output logic                    word_done,
    output logic [8*WORD_BYTES-1:0] word
);
    localparam int LANE_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

    logic [LANE_W-1:0]       lane;
    logic [8*WORD_BYTES-1:0] acc;

    // NOTE: word gets a full default before the lane insert so no latch is inferred.
    always_comb begin
        word = acc;
        for (int i = 0; i < WORD_BYTES; i++) begin
            if (int'(lane) == i) begin
                if (BIG_ENDIAN != 0) word[8*(WORD_BYTES-1-i) +: 8] = byte_in;
                else                 word[8*i +: 8]                = byte_in;
            end
        end
    end

    assign word_done = push && (last || int'(lane) == WORD_BYTES - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane <= '0;
            acc  <= '0;
        end else if (flush || word_done) begin
            lane <= '0;
            acc  <= '0;
        end else if (push) begin
            lane <= lane + 1'b1;
            acc  <= word;
        end
    end

endmodule

// File: rtl/hqc_frame_loader.sv
// Frame loader: parses A5/region/length/payload/XOR-checksum frames from the
// RX byte stream, writes packed words to the selected region, tracks loads.
module hqc_frame_loader
    import hqc_loader_pkg::*;
#(
    parameter int          WORD_BYTES  = 8,
    parameter int          NUM_REGIONS = 4,
    parameter int          ADDR_W      = 12,
    parameter int          BIG_ENDIAN  = 0,
    parameter int unsigned TIMEOUT_CYC = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    hqc_frame_loader_if.master     bus,
    input  logic [NUM_REGIONS-1:0] required_mask,
    input  logic                   clear,
    output logic [NUM_REGIONS-1:0] loaded_mask,
    output logic                   all_loaded,
    output logic                   err,
    output logic [1:0]             err_code,
    output logic                   busy
);
    localparam int          REG_W   = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;
    localparam int unsigned MAX_LEN = WORD_BYTES << ADDR_W;

    state_t                  state;
    logic [REG_W-1:0]        region_q;
    logic                    hdr_ok_q;
    logic [7:0]              len_lo_q;
    logic [15:0]             remain_q;
    logic [7:0]              csum_q;
    logic [ADDR_W-1:0]       addr_cnt;
    logic [31:0]             tcnt;
    logic                    cond_q;

    logic                    accept;
    logic [15:0]             len_full;
    logic                    hdr_bad;
    logic                    data_push;
    logic                    last_byte;
    logic                    timeout_hit;
    logic                    csum_set;
    logic                    word_done;
    logic [8*WORD_BYTES-1:0] word;
    logic [NUM_REGIONS-1:0]  mask_next;
    logic                    cond_next;

    assign bus.in_ready = ~rst;
    assign accept       = bus.in_valid && bus.in_ready;
    assign busy         = (state != ST_IDLE);
    assign len_full     = {bus.in_data, len_lo_q};
    assign hdr_bad      = !hdr_ok_q || (len_full == 16'd0) || (32'(len_full) > MAX_LEN);
    assign last_byte    = (remain_q == 16'd1);
    assign data_push    = accept && (state == ST_DATA);
    assign csum_set     = accept && (state == ST_CSUM) && (bus.in_data == csum_q);
    // The idle gap is measured in edges since the last accept, so the error
    // rises exactly TIMEOUT_CYC edges after it.
    assign timeout_hit  = (TIMEOUT_CYC != 0) && (state != ST_IDLE) && !accept
                          && (tcnt == 32'(TIMEOUT_CYC - 1));

    hqc_word_packer #(
        .WORD_BYTES (WORD_BYTES),
        .BIG_ENDIAN (BIG_ENDIAN)
    ) u_packer (
        .clk       (clk),
        .rst       (rst),
        .flush     (timeout_hit),
        .push      (data_push),
        .last      (last_byte),
        .byte_in   (bus.in_data),
        .word_done (word_done),
        .word      (word)
    );

    // clear has priority over a checksum-good set landing in the same cycle.
    always_comb begin
        mask_next = loaded_mask;
        if (clear)         mask_next = '0;
        else if (csum_set) mask_next[region_q] = 1'b1;
    end

    assign cond_next = (|required_mask) && ((mask_next & required_mask) == required_mask);

    // NOTE: sequential state uses non-blocking assignments only, so every read sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            region_q      <= '0;
            hdr_ok_q      <= 1'b0;
            len_lo_q      <= '0;
            remain_q      <= '0;
            csum_q        <= '0;
            addr_cnt      <= '0;
            tcnt          <= '0;
            cond_q        <= 1'b0;
            loaded_mask   <= '0;
            all_loaded    <= 1'b0;
            err           <= 1'b0;
            err_code      <= ERR_NONE;
            bus.wr_en     <= 1'b0;
            bus.wr_region <= '0;
            bus.wr_addr   <= '0;
            bus.wr_data   <= '0;
        end else begin
            bus.wr_en   <= 1'b0;
            err         <= 1'b0;
            loaded_mask <= mask_next;
            cond_q      <= cond_next;
            all_loaded  <= cond_next && !cond_q;

            if (accept || state == ST_IDLE || TIMEOUT_CYC == 0) tcnt <= '0;
            else                                                tcnt <= tcnt + 32'd1;

            if (word_done) begin
                bus.wr_en     <= 1'b1;
                bus.wr_region <= region_q;
                bus.wr_addr   <= addr_cnt;
                bus.wr_data   <= word;
                addr_cnt      <= addr_cnt + 1'b1;
            end

            if (timeout_hit) begin
                err      <= 1'b1;
                err_code <= ERR_TIMEOUT;
                state    <= ST_IDLE;
            end else if (accept) begin
                case (state)
                    ST_IDLE: if (bus.in_data == SYNC_BYTE) state <= ST_HDR;
                    ST_HDR: begin
                        hdr_ok_q <= (bus.in_data[7:4] == 4'd0)
                                    && ({1'b0, bus.in_data[3:0]} < 5'(NUM_REGIONS));
                        region_q <= bus.in_data[REG_W-1:0];
                        addr_cnt <= '0;
                        csum_q   <= '0;
                        state    <= ST_LEN0;
                    end
                    ST_LEN0: begin
                        len_lo_q <= bus.in_data;
                        state    <= ST_LEN1;
                    end
                    ST_LEN1: begin
                        if (hdr_bad) begin
                            err      <= 1'b1;
                            err_code <= ERR_HDR;
                            state    <= ST_IDLE;
                        end else begin
                            remain_q <= len_full;
                            state    <= ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        csum_q   <= csum_q ^ bus.in_data;
                        remain_q <= remain_q - 16'd1;
                        if (last_byte) state <= ST_CSUM;
                    end
                    ST_CSUM: begin
                        if (bus.in_data != csum_q) begin
                            err      <= 1'b1;
                            err_code <= ERR_CSUM;
                        end
                        state <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
